// File: rtl/sliding_window_gen_pkg.sv
// Shared definitions for the 3x3 sliding-window generator.
// Tap indices follow raster order inside the window (top-left .. bottom-right).
// Also holds the frame FSM encoding and the pixel-width helper.
package sliding_window_gen_pkg;

  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;
  localparam int NUM_TAPS = 9;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } win_state_t;

  // Width of one packed multi-channel pixel.
  function automatic int pix_width(input int ch, input int wi);
    return ch * wi;
  endfunction

endpackage

// File: rtl/sliding_window_gen_linebuf.sv
// Purpose: DEPTH-entry delay line, one write and one read per enable, for row storage.
// Latency: read data registered, valid the cycle after the enable that fetched it.
// Backpressure: none; pointers only move on en, so input gaps freeze the line.
module sliding_linebuf #(
  parameter int DEPTH   = 128,
  parameter int DW      = 8,
  // Read pointer starts this many slots ahead of the write pointer, which
  // shortens the effective delay when the write data is itself one step late.
  parameter int RD_LEAD = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] RD_INIT  = AW'(RD_LEAD % DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage and registered read; contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[wr_ptr] <= wr_data;
      rd_data     <= mem[rd_ptr];
    end
  end

  // Circular pointers, advanced together so their offset never drifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= RD_INIT;
    end else if (en) begin
      wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
      rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
    end
  end

endmodule

// File: rtl/sliding_window_gen.sv
// Purpose: raster pixel stream -> zero-padded 3x3 (or 1x1) window per pixel, CH channels.
// Latency: window for the accept at cycle t appears at t+2; last IMG_W+1 windows come from a flush.
// Backpressure: rdy_o drops only during the end-of-frame flush; no output backpressure.
module sliding_window_gen
  import sliding_window_gen_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int CH    = 1,
  parameter int WI    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_conv3x3,
  input  logic                  vld_i,
  output logic                  rdy_o,
  input  logic [CH*WI-1:0]      din,
  output logic                  vld_o,
  output logic [9*CH*WI-1:0]    win_o,
  output logic                  sof_o,
  output logic                  frame_done
);

  localparam int PIX_W = pix_width(CH, WI);
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  // Row counter also walks the virtual rows IMG_H and IMG_H+1 during flush.
  localparam int RW    = $clog2(IMG_H + 2);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(IMG_H + 1);

  win_state_t        state;
  win_state_t        state_nxt;
  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  logic              acc;
  logic              adv;
  logic              flushing;
  logic              mode_q;

  logic              emit_now;
  logic              sof_now;
  logic              last_now;
  logic [RW-1:0]     c_row;
  logic [CW-1:0]     c_col;

  logic              emit_s1;
  logic              adv_s1;
  logic              sof_s1;
  logic              last_s1;
  logic [RW-1:0]     c_row_s1;
  logic [CW-1:0]     c_col_s1;
  logic [PIX_W-1:0]  pix_s1;
  logic [PIX_W-1:0]  mid_rd;
  logic [PIX_W-1:0]  top_rd;

  logic [PIX_W-1:0]  col_a [3];
  logic [PIX_W-1:0]  col_b [3];
  logic [PIX_W-1:0]  tap   [NUM_TAPS];
  logic [9*PIX_W-1:0] win_nxt;

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: fill until the first window is due, run to the last pixel, then flush.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL:  if (acc && row_cnt == RW'(1) && col_cnt == '0) state_nxt = ST_RUN;
      ST_RUN:   if (acc && row_cnt == ROW_LAST && col_cnt == COL_LAST) state_nxt = ST_FLUSH;
      ST_FLUSH: if (row_cnt == ROW_END) state_nxt = ST_FILL;
      default:  state_nxt = ST_FILL;
    endcase
  end

  // FSM outputs: the input is stalled only while flushing.
  always_comb begin
    rdy_o    = 1'b1;
    flushing = 1'b0;
    if (state == ST_FLUSH) begin
      rdy_o    = 1'b0;
      flushing = 1'b1;
    end
  end

  // Handshake: flush cycles step the pipeline like virtual accepts.
  always_comb begin
    acc = vld_i & rdy_o;
    adv = acc | flushing;
  end

  // Raster position of the pixel (real or virtual) being taken this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (adv) begin
      if (flushing && row_cnt == ROW_END) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end else if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  // Mode is captured on the first pixel of each frame and held for the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b1;
    end else if (acc && row_cnt == '0 && col_cnt == '0) begin
      mode_q <= is_conv3x3;
    end
  end

  // Window centre lags the incoming pixel by one row plus one column.
  always_comb begin
    emit_now = adv && ((row_cnt > RW'(1)) || (row_cnt == RW'(1) && col_cnt != '0));
    if (col_cnt == '0) begin
      c_row = row_cnt - RW'(2);
      c_col = COL_LAST;
    end else begin
      c_row = row_cnt - RW'(1);
      c_col = col_cnt - CW'(1);
    end
    sof_now  = emit_now && row_cnt == RW'(1) && col_cnt == CW'(1);
    last_now = emit_now && c_row == ROW_LAST && c_col == COL_LAST;
  end

  // Stage-1 control, aligned with the line-buffer read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      emit_s1  <= 1'b0;
      adv_s1   <= 1'b0;
      sof_s1   <= 1'b0;
      last_s1  <= 1'b0;
      c_row_s1 <= '0;
      c_col_s1 <= '0;
    end else begin
      emit_s1  <= emit_now;
      adv_s1   <= adv;
      sof_s1   <= sof_now;
      last_s1  <= last_now;
      c_row_s1 <= c_row;
      c_col_s1 <= c_col;
    end
  end

  // Stage-1 copy of the new pixel; virtual flush pixels are zero.
  always_ff @(posedge clk) begin
    if (adv) begin
      pix_s1 <= acc ? din : '0;
    end
  end

  // Row r (pixel p-IMG_W) comes straight from the incoming stream.
  sliding_linebuf #(
    .DEPTH   (IMG_W),
    .DW      (PIX_W),
    .RD_LEAD (0)
  ) u_lb_mid (
    .clk     (clk),
    .rst     (rst),
    .en      (adv),
    .wr_data (acc ? din : '0),
    .rd_data (mid_rd)
  );

  // Row r-1 (pixel p-2*IMG_W): fed from the middle buffer's output, which is
  // one step stale at write time, hence the one-slot read lead.
  sliding_linebuf #(
    .DEPTH   (IMG_W),
    .DW      (PIX_W),
    .RD_LEAD (1)
  ) u_lb_top (
    .clk     (clk),
    .rst     (rst),
    .en      (adv),
    .wr_data (mid_rd),
    .rd_data (top_rd)
  );

  // Columns c-1 and c of the window; the newest column is used combinationally.
  always_ff @(posedge clk) begin
    if (adv_s1) begin
      col_a[0] <= col_b[0];
      col_a[1] <= col_b[1];
      col_a[2] <= col_b[2];
      col_b[0] <= top_rd;
      col_b[1] <= mid_rd;
      col_b[2] <= pix_s1;
    end
  end

  // Assemble the 3x3 neighbourhood in tap order.
  always_comb begin
    tap[TAP_TL] = col_a[0];
    tap[TAP_TC] = col_b[0];
    tap[TAP_TR] = top_rd;
    tap[TAP_ML] = col_a[1];
    tap[TAP_MC] = col_b[1];
    tap[TAP_MR] = mid_rd;
    tap[TAP_BL] = col_a[2];
    tap[TAP_BC] = col_b[2];
    tap[TAP_BR] = pix_s1;
  end

  // Zero every tap outside the frame (this also hides stale buffer data), or all but the centre in 1x1 mode.
  always_comb begin
    logic pad_top;
    logic pad_bot;
    logic pad_left;
    logic pad_right;
    logic keep;
    pad_top   = (c_row_s1 == '0);
    pad_bot   = (c_row_s1 == ROW_LAST);
    pad_left  = (c_col_s1 == '0);
    pad_right = (c_col_s1 == COL_LAST);
    win_nxt   = '0;
    keep      = 1'b0;
    for (int t = 0; t < NUM_TAPS; t++) begin
      keep = 1'b1;
      if ((t / 3) == 0 && pad_top)   keep = 1'b0;
      if ((t / 3) == 2 && pad_bot)   keep = 1'b0;
      if ((t % 3) == 0 && pad_left)  keep = 1'b0;
      if ((t % 3) == 2 && pad_right) keep = 1'b0;
      if (!mode_q && t != TAP_MC)    keep = 1'b0;
      win_nxt[t*PIX_W +: PIX_W] = keep ? tap[t] : '0;
    end
  end

  // Output register; the window holds its last value between valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_o      <= 1'b0;
      sof_o      <= 1'b0;
      frame_done <= 1'b0;
      win_o      <= '0;
    end else begin
      vld_o      <= emit_s1;
      sof_o      <= sof_s1;
      frame_done <= last_s1;
      if (emit_s1) begin
        win_o <= win_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Bench for sliding_window_gen on a 4x3 frame with pixel value p+1.
// Expected windows come from a hand-computed table; a monitor queues every output window.
// Covers reset, latency, padding, flush, input gaps, 1x1 mode and mid-frame reset.
module tb_sliding_window_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_conv3x3;
  logic        vld_i;
  logic        rdy_o;
  logic [7:0]  din;
  logic        vld_o;
  logic [71:0] win_o;
  logic        sof_o;
  logic        frame_done;

  sliding_window_gen #(
    .IMG_W (4),
    .IMG_H (3),
    .CH    (1),
    .WI    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .is_conv3x3 (is_conv3x3),
    .vld_i      (vld_i),
    .rdy_o      (rdy_o),
    .din        (din),
    .vld_o      (vld_o),
    .win_o      (win_o),
    .sof_o      (sof_o),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] win;
    logic        sof;
    logic        done;
  } vec_t;

  typedef struct {
    logic [71:0] win;
    logic        sof;
    logic        done;
    int          cyc;
  } mon_t;

  vec_t tbl [12];
  mon_t mon_q [$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   acc6_cyc;
  int   last_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    mon_t m;
    if (vld_o) begin
      m.win  = win_o;
      m.sof  = sof_o;
      m.done = frame_done;
      m.cyc  = cyc;
      mon_q.push_back(m);
    end
  end

  function automatic logic [71:0] w9(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5,
                                     input int a6, input int a7, input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Send n pixels (value p+1). Mode is presented on p=0 and inverted afterwards.
  task automatic send_frame(input int n, input bit mode, input bit gaps, input bit flush_chk);
    logic [5:0] rdy_hist;
    for (int p = 0; p < n; p++) begin
      int idle;
      int g;
      idle = gaps ? ((p % 2 == 1) ? $urandom_range(0, 160) : 1) : 0;
      vld_i = 1'b0;
      din   = 8'hEE;
      repeat (idle) @(negedge clk);
      vld_i      = 1'b1;
      din        = 8'(p + 1);
      is_conv3x3 = (p == 0) ? mode : ~mode;
      g = 0;
      while (!rdy_o && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (!rdy_o) begin
        n_tests++;
        n_fail++;
        $display("FAIL rdy_wait: got rdy_o=0 want 1 at pixel %0d", p);
      end
      if (p == 5)     acc6_cyc = cyc;
      if (p == n - 1) last_cyc = cyc;
      @(negedge clk);
    end
    if (flush_chk) begin
      // Keep offering junk during flush; it must be ignored.
      din = 8'hEE;
      for (int j = 0; j < 6; j++) begin
        if (j == 5) vld_i = 1'b0;
        rdy_hist[j] = rdy_o;
        @(negedge clk);
      end
      check("flush_rdy_pattern", 72'(rdy_hist), 72'(6'b100000));
    end
    vld_i = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (mon_q.size() < 12 && g < 400) begin
      @(negedge clk);
      g++;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic cmp_frame(input string tag, input bit one_by_one);
    logic [71:0] exp_w;
    logic [71:0] act_w;
    logic [1:0]  act_f;
    check({tag, " count"}, 72'(mon_q.size()), 72'd12);
    for (int i = 0; i < 12; i++) begin
      exp_w = one_by_one ? (tbl[i].win & (72'hFF << 32)) : tbl[i].win;
      act_w = (i < mon_q.size()) ? mon_q[i].win : 'x;
      act_f = (i < mon_q.size()) ? {mon_q[i].sof, mon_q[i].done} : 2'bxx;
      check($sformatf("%s win%0d", tag, i), act_w, exp_w);
      check($sformatf("%s sof_done%0d", tag, i), 72'(act_f), 72'({tbl[i].sof, tbl[i].done}));
    end
  endtask

  task automatic cmp_timing(input string tag);
    int c0;
    c0 = (mon_q.size() > 0) ? mon_q[0].cyc : -1;
    check({tag, " first_latency"}, 72'(c0 - acc6_cyc), 72'd2);
    for (int j = 0; j < 5; j++) begin
      int c;
      c = (mon_q.size() > 7 + j) ? mon_q[7 + j].cyc : -1;
      check($sformatf("%s flush_cycle%0d", tag, j), 72'(c - last_cyc), 72'(3 + j));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{w9(0,0,0, 0,1,2,   0,5,6),    1'b1, 1'b0};
    tbl[1]  = '{w9(0,0,0, 1,2,3,   5,6,7),    1'b0, 1'b0};
    tbl[2]  = '{w9(0,0,0, 2,3,4,   6,7,8),    1'b0, 1'b0};
    tbl[3]  = '{w9(0,0,0, 3,4,0,   7,8,0),    1'b0, 1'b0};
    tbl[4]  = '{w9(0,1,2, 0,5,6,   0,9,10),   1'b0, 1'b0};
    tbl[5]  = '{w9(1,2,3, 5,6,7,   9,10,11),  1'b0, 1'b0};
    tbl[6]  = '{w9(2,3,4, 6,7,8,   10,11,12), 1'b0, 1'b0};
    tbl[7]  = '{w9(3,4,0, 7,8,0,   11,12,0),  1'b0, 1'b0};
    tbl[8]  = '{w9(0,5,6, 0,9,10,  0,0,0),    1'b0, 1'b0};
    tbl[9]  = '{w9(5,6,7, 9,10,11, 0,0,0),    1'b0, 1'b0};
    tbl[10] = '{w9(6,7,8, 10,11,12, 0,0,0),   1'b0, 1'b0};
    tbl[11] = '{w9(7,8,0, 11,12,0, 0,0,0),    1'b0, 1'b1};

    rst        = 1'b1;
    vld_i      = 1'b0;
    din        = 8'h00;
    is_conv3x3 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset rdy_o", 72'(rdy_o), 72'd1);
    check("reset vld_o", 72'(vld_o), 72'd0);
    check("reset win_o", win_o, 72'd0);
    check("reset sof_o", 72'(sof_o), 72'd0);
    check("reset frame_done", 72'(frame_done), 72'd0);

    // Back-to-back 3x3 frame with flush checks.
    mon_q.delete();
    send_frame(12, 1'b1, 1'b0, 1'b1);
    drain();
    cmp_frame("b2b", 1'b0);
    cmp_timing("b2b");

    // Same frame with input stalls.
    mon_q.delete();
    send_frame(12, 1'b1, 1'b1, 1'b0);
    drain();
    cmp_frame("gaps", 1'b0);

    // 1x1 mode; the mode input flips after the first pixel and must be ignored.
    mon_q.delete();
    send_frame(12, 1'b0, 1'b0, 1'b0);
    drain();
    cmp_frame("1x1", 1'b1);

    // Partial frame, reset, then a clean frame.
    send_frame(7, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1 mon_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(12, 1'b1, 1'b0, 1'b1);
    drain();
    cmp_frame("after_rst", 1'b0);
    cmp_timing("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
